// File: rtl/m68k_bus_target.sv
// Responder end of a 68000-style asynchronous bus: decodes a bus cycle, runs one
// request/acknowledge transaction on the device port and terminates with DTACK, BERR or VPA.
module m68k_bus_target #(
  parameter logic [23:0] ADDR_BASE  = 24'hFF8000,
  parameter logic [23:0] ADDR_MASK  = 24'hFF8000,
  parameter bit          SUPER_ONLY = 1'b1,
  parameter logic [7:0]  TIMEOUT    = 8'd64,
  parameter bit          IACK_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phi1,
  input  logic        phi2,
  input  logic        as_n,
  input  logic        rw_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic [2:0]  fc,
  input  logic [23:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        dtack_n,
  output logic        berr,
  output logic        vpa_n,
  input  logic        ivec_valid,
  input  logic [7:0]  ivec,
  output logic [2:0]  iack_level,
  output logic        dev_req,
  output logic        dev_we,
  output logic [22:0] dev_addr,
  output logic [1:0]  dev_be,
  output logic [15:0] dev_wdata,
  input  logic [15:0] dev_rdata,
  input  logic        dev_ack
);

  typedef enum logic [2:0] {IDLE, DECODE, ACCESS, IACK, RESP, ERR, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  count_reg, count_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [22:0] daddr_reg, daddr_next;
  logic [1:0]  be_reg, be_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [15:0] rdata_reg, rdata_next;
  logic        load_reg, load_next;
  logic [15:0] dout_reg, dout_next;
  logic        dtack_reg, dtack_next;
  logic        vpa_reg, vpa_next;
  logic        berr_reg, berr_next;
  logic [2:0]  level_reg, level_next;

  logic        bus_edge, hit, is_iack, strobe, tick, timeout_hit;
  logic [7:0]  count_inc;
  logic [23:0] mask_eff;
  logic        unused_bits;

  assign unused_bits = addr[0];
  assign mask_eff    = ADDR_MASK & 24'hFFFFFE;
  assign bus_edge    = phi1 | phi2;
  assign hit         = (addr & mask_eff) == (ADDR_BASE & mask_eff);
  assign is_iack     = (fc == 3'b111) && (addr[19:16] == 4'hF);
  assign strobe      = !(uds_n && lds_n);
  assign count_inc   = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
  // The counter also runs for an orphaned request left behind by an aborted cycle,
  // so a device that never answers cannot hold dev_req forever.
  assign tick        = phi2 && ((state_reg != IDLE) || req_reg);
  assign timeout_hit = tick && (count_reg != TIMEOUT) && (count_inc == TIMEOUT);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    daddr_next = daddr_reg;
    be_next    = be_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    load_next  = load_reg;
    dout_next  = dout_reg;
    dtack_next = dtack_reg;
    vpa_next   = vpa_reg;
    berr_next  = berr_reg;
    level_next = level_reg;

    if (tick) count_next = count_inc;

    if (req_reg && dev_ack) begin
      req_next = 1'b0;
      if (state_reg == ACCESS && !we_reg) begin
        rdata_next = dev_rdata;
        load_next  = 1'b1;
      end
    end else if (req_reg && timeout_hit) begin
      req_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (bus_edge && !as_n) begin
          state_next = DECODE;
          count_next = 8'd0;
          load_next  = 1'b0;
        end
      end
      DECODE: begin
        if (bus_edge) begin
          if (as_n) begin
            state_next = IDLE;
          end else if (is_iack && IACK_EN) begin
            state_next = IACK;
            level_next = addr[3:1];
          end else if (!hit) begin
            state_next = IDLE;
          end else if ((SUPER_ONLY && !fc[2]) || timeout_hit) begin
            state_next = ERR;
            berr_next  = 1'b1;
          end else if (strobe && !req_reg) begin
            state_next = ACCESS;
            req_next   = 1'b1;
            we_next    = !rw_n;
            daddr_next = addr[23:1];
            be_next    = {!uds_n, !lds_n};
            wdata_next = din;
          end
        end
      end
      ACCESS: begin
        // An abort leaves req_reg alone: an issued request finishes on the device quietly.
        if (bus_edge && as_n) begin
          state_next = IDLE;
        end else if (req_reg && dev_ack) begin
          state_next = RESP;
        end else if (timeout_hit) begin
          state_next = ERR;
          berr_next  = 1'b1;
        end
      end
      IACK: begin
        if (bus_edge) begin
          if (as_n) begin
            state_next = IDLE;
            level_next = 3'd0;
          end else if (ivec_valid) begin
            state_next = RESP;
            rdata_next = {8'h00, ivec};
            load_next  = 1'b1;
          end else begin
            state_next = HOLD;
            vpa_next   = 1'b0;
          end
        end
      end
      RESP: begin
        if (bus_edge) begin
          state_next = HOLD;
          dtack_next = 1'b0;
          if (load_reg) dout_next = rdata_reg;
        end
      end
      ERR, HOLD: begin
        if (bus_edge && as_n) begin
          state_next = IDLE;
          dtack_next = 1'b1;
          vpa_next   = 1'b1;
          berr_next  = 1'b0;
          level_next = 3'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 8'd0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      daddr_reg <= 23'd0;
      be_reg    <= 2'b00;
      wdata_reg <= 16'd0;
      rdata_reg <= 16'd0;
      load_reg  <= 1'b0;
      dout_reg  <= 16'd0;
      dtack_reg <= 1'b1;
      vpa_reg   <= 1'b1;
      berr_reg  <= 1'b0;
      level_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      daddr_reg <= daddr_next;
      be_reg    <= be_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      load_reg  <= load_next;
      dout_reg  <= dout_next;
      dtack_reg <= dtack_next;
      vpa_reg   <= vpa_next;
      berr_reg  <= berr_next;
      level_reg <= level_next;
    end
  end

  assign dout       = dout_reg;
  assign dtack_n    = dtack_reg;
  assign vpa_n      = vpa_reg;
  assign berr       = berr_reg;
  assign iack_level = level_reg;
  assign dev_req    = req_reg;
  assign dev_we     = we_reg;
  assign dev_addr   = daddr_reg;
  assign dev_be     = be_reg;
  assign dev_wdata  = wdata_reg;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Self-checking bench for m68k_bus_target: a behavioural bus master, a memory-backed
// device responder and a word-array reference model of the region contents.
module tb_m68k_bus_target;
  logic        clk, reset, phi1, phi2, as_n, rw_n, uds_n, lds_n;
  logic [2:0]  fc;
  logic [23:0] addr;
  logic [15:0] din, dout;
  logic        dtack_n, berr, vpa_n, ivec_valid;
  logic [7:0]  ivec;
  logic [2:0]  iack_level;
  logic        dev_req, dev_we, dev_ack;
  logic [22:0] dev_addr;
  logic [1:0]  dev_be;
  logic [15:0] dev_wdata, dev_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  bit ack_on = 1'b1;
  int late_pulse = 0;
  int late_seen = 0;
  bit force_rd = 1'b0;
  logic [15:0] force_val = 16'h0;
  int req_clks = 0;
  logic [15:0] dev_mem [16];
  logic [15:0] ref_mem [16];
  int phase = 0;

  m68k_bus_target #(.TIMEOUT(8'd8)) dut (
    .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2), .as_n(as_n), .rw_n(rw_n),
    .uds_n(uds_n), .lds_n(lds_n), .fc(fc), .addr(addr), .din(din), .dout(dout),
    .dtack_n(dtack_n), .berr(berr), .vpa_n(vpa_n), .ivec_valid(ivec_valid), .ivec(ivec),
    .iack_level(iack_level), .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
    .dev_be(dev_be), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ack(dev_ack)
  );

  function automatic logic [15:0] init_word(input int i);
    return 16'h1357 ^ (16'(i) * 16'h0F1F);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus clock enables: phi1 and phi2 each one clk wide, alternating every two clks.
  initial begin
    phi1 = 1'b0;
    phi2 = 1'b0;
    forever begin
      @(negedge clk);
      phase = (phase + 1) % 4;
      phi1 = (phase == 0);
      phi2 = (phase == 2);
    end
  end

  // Device: acknowledges ack_delay clks after seeing dev_req, backed by dev_mem.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    dev_ack = 1'b0;
    dev_rdata = 16'h0;
    for (int i = 0; i < 16; i++) dev_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      dev_ack = 1'b0;
      if (late_pulse != late_seen) begin
        late_seen = late_pulse;
        dev_ack = 1'b1;
        dev_rdata = 16'hDEAD;
      end else if (dev_req && ack_on) begin
        if (wait_cnt >= ack_delay) begin
          dev_ack = 1'b1;
          dev_rdata = force_rd ? force_val : dev_mem[dev_addr[3:0]];
          if (dev_we) begin
            if (dev_be[1]) dev_mem[dev_addr[3:0]][15:8] = dev_wdata[15:8];
            if (dev_be[0]) dev_mem[dev_addr[3:0]][7:0] = dev_wdata[7:0];
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (dev_req) req_clks++;
    end
  end

  task automatic wait_bus_edge();
    do @(posedge clk); while (!(phi1 || phi2));
    #1;
  endtask

  // Master side of one bus cycle up to the first terminator (or max_edges bus edges).
  // term: 0 none, 1 dtack, 2 berr, 3 vpa.
  task automatic run_cycle(input logic [23:0] a, input logic [2:0] f, input logic rw,
                           input logic [1:0] be, input logic [15:0] wd, input int sdly,
                           input int max_edges, output int term, output int n_phi2,
                           output bit early_req, output bit multi, output logic [2:0] lvl);
    int e;
    int k;
    addr = a; fc = f; rw_n = rw; din = wd;
    term = 0; n_phi2 = 0; early_req = 1'b0; multi = 1'b0; lvl = 3'd0;
    if (sdly == 0) begin
      uds_n = ~be[1];
      lds_n = ~be[0];
    end
    as_n = 1'b0;
    e = 0;
    while (e < max_edges && term == 0) begin
      wait_bus_edge();
      if (e > 0 && phi2) n_phi2++;
      if (e < sdly && dev_req) early_req = 1'b1;
      k = int'(!dtack_n) + int'(berr) + int'(!vpa_n);
      if (k > 1) multi = 1'b1;
      if (!dtack_n) term = 1;
      else if (berr) term = 2;
      else if (!vpa_n) term = 3;
      lvl = iack_level;
      if (e + 1 == sdly) begin
        uds_n = ~be[1];
        lds_n = ~be[0];
      end
      e++;
    end
    $display("cycle addr=%h fc=%0d rw=%0b be=%b term=%0d dout=%h", a, f, rw, be, term, dout);
  endtask

  task automatic end_cycle(output bit released);
    as_n = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    wait_bus_edge();
    released = dtack_n && vpa_n && !berr && (iack_level == 3'd0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL reset_dtack: got %b want 1", dtack_n); end
    n_checks++; if (vpa_n !== 1'b1) begin n_fail++; $display("FAIL reset_vpa: got %b want 1", vpa_n); end
    n_checks++; if (berr !== 1'b0) begin n_fail++; $display("FAIL reset_berr: got %b want 0", berr); end
    n_checks++; if (dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0000", dout); end
    n_checks++; if (dev_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", dev_req); end
    n_checks++; if (iack_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", iack_level); end
    @(negedge clk);
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_read();
    int term, np; bit er, mu, rel; logic [2:0] lv; int r0;
    force_rd = 1'b1; force_val = 16'hBEEF; ack_delay = 0; r0 = req_clks;
    run_cycle(24'hFF8002, 3'b101, 1'b1, 2'b11, 16'h0, 0, 20, term, np, er, mu, lv);
    force_rd = 1'b0;
    n_checks++; if (term !== 1) begin n_fail++; $display("FAIL read_term: got %0d want 1", term); end
    n_checks++; if (np > 1) begin n_fail++; $display("FAIL read_waitstates: got %0d phi2 want <=1", np); end
    n_checks++; if (dev_be !== 2'b11) begin n_fail++; $display("FAIL read_be: got %b want 11", dev_be); end
    n_checks++; if (dev_addr !== 23'h7FC001) begin n_fail++; $display("FAIL read_addr: got %h want 7fc001", dev_addr); end
    n_checks++; if (dev_we !== 1'b0) begin n_fail++; $display("FAIL read_we: got %b want 0", dev_we); end
    n_checks++; if (dout !== 16'hBEEF) begin n_fail++; $display("FAIL read_dout: got %h want beef", dout); end
    n_checks++; if (req_clks == r0) begin n_fail++; $display("FAIL read_req: got no dev_req want dev_req"); end
    end_cycle(rel);
    n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL read_release: got %b want 1", rel); end
    n_checks++; if (dout !== 16'hBEEF) begin n_fail++; $display("FAIL read_dout_hold: got %h want beef", dout); end
  endtask

  task automatic test_byte_write();
    int term, np; bit er, mu, rel; logic [2:0] lv;
    ack_delay = 1;
    run_cycle(24'hFF8005, 3'b101, 1'b0, 2'b01, 16'h00A5, 2, 20, term, np, er, mu, lv);
    ref_mem[2][7:0] = 8'hA5;
    n_checks++; if (term !== 1) begin n_fail++; $display("FAIL wr_term: got %0d want 1", term); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_early_req: got %b want 0", er); end
    n_checks++; if (dev_we !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b want 1", dev_we); end
    n_checks++; if (dev_be !== 2'b01) begin n_fail++; $display("FAIL wr_be: got %b want 01", dev_be); end
    n_checks++; if (dev_wdata !== 16'h00A5) begin n_fail++; $display("FAIL wr_wdata: got %h want 00a5", dev_wdata); end
    n_checks++; if (dev_addr !== 23'h7FC002) begin n_fail++; $display("FAIL wr_addr: got %h want 7fc002", dev_addr); end
    end_cycle(rel);
    n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL wr_release: got %b want 1", rel); end
    run_cycle(24'hFF8004, 3'b110, 1'b1, 2'b11, 16'h0, 0, 20, term, np, er, mu, lv);
    n_checks++; if (dout !== ref_mem[2]) begin n_fail++; $display("FAIL wr_readback: got %h want %h", dout, ref_mem[2]); end
    end_cycle(rel);
  endtask

  task automatic test_user_berr();
    int term, np; bit er, mu, rel; logic [2:0] lv; int r0;
    r0 = req_clks;
    run_cycle(24'hFF8000, 3'b001, 1'b1, 2'b11, 16'h0, 0, 20, term, np, er, mu, lv);
    n_checks++; if (term !== 2) begin n_fail++; $display("FAIL user_term: got %0d want 2", term); end
    n_checks++; if (mu !== 1'b0) begin n_fail++; $display("FAIL user_multi: got %b want 0", mu); end
    n_checks++; if (req_clks != r0) begin n_fail++; $display("FAIL user_req: got %0d req clks want 0", req_clks - r0); end
    repeat (3) wait_bus_edge();
    n_checks++; if (berr !== 1'b1) begin n_fail++; $display("FAIL user_berr_held: got %b want 1", berr); end
    end_cycle(rel);
    n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL user_release: got %b want 1", rel); end
  endtask

  task automatic test_timeout();
    int term, np; bit er, mu, rel; logic [2:0] lv; logic [15:0] d0;
    ack_on = 1'b0;
    d0 = dout;
    run_cycle(24'hFF8010, 3'b101, 1'b1, 2'b11, 16'h0, 0, 40, term, np, er, mu, lv);
    n_checks++; if (term !== 2) begin n_fail++; $display("FAIL to_term: got %0d want 2", term); end
    n_checks++; if (np !== 8) begin n_fail++; $display("FAIL to_phi2: got %0d want 8", np); end
    n_checks++; if (dev_req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %b want 0", dev_req); end
    late_pulse++;
    repeat (4) @(negedge clk);
    n_checks++; if (berr !== 1'b1) begin n_fail++; $display("FAIL to_late_berr: got %b want 1", berr); end
    n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL to_late_dtack: got %b want 1", dtack_n); end
    n_checks++; if (dout !== d0) begin n_fail++; $display("FAIL to_late_dout: got %h want %h", dout, d0); end
    end_cycle(rel);
    n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL to_release: got %b want 1", rel); end
    ack_on = 1'b1;
  endtask

  task automatic test_iack();
    int term, np; bit er, mu, rel; logic [2:0] lv;
    ivec_valid = 1'b1; ivec = 8'h45;
    run_cycle(24'hFFFFF9, 3'b111, 1'b1, 2'b01, 16'h0, 0, 20, term, np, er, mu, lv);
    n_checks++; if (term !== 1) begin n_fail++; $display("FAIL iack_vec_term: got %0d want 1", term); end
    n_checks++; if (dout !== 16'h0045) begin n_fail++; $display("FAIL iack_vec_dout: got %h want 0045", dout); end
    n_checks++; if (lv !== 3'd4) begin n_fail++; $display("FAIL iack_vec_level: got %0d want 4", lv); end
    end_cycle(rel);
    n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL iack_vec_release: got %b want 1", rel); end
    ivec_valid = 1'b0;
    run_cycle(24'hFFFFF9, 3'b111, 1'b1, 2'b01, 16'h0, 0, 20, term, np, er, mu, lv);
    n_checks++; if (term !== 3) begin n_fail++; $display("FAIL iack_auto_term: got %0d want 3", term); end
    n_checks++; if (mu !== 1'b0) begin n_fail++; $display("FAIL iack_auto_multi: got %b want 0", mu); end
    n_checks++; if (lv !== 3'd4) begin n_fail++; $display("FAIL iack_auto_level: got %0d want 4", lv); end
    end_cycle(rel);
    n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL iack_auto_release: got %b want 1", rel); end
  endtask

  task automatic test_miss();
    int term, np; bit er, mu, rel; logic [2:0] lv; int r0; logic [15:0] d0;
    r0 = req_clks; d0 = dout;
    run_cycle(24'h001000, 3'b101, 1'b1, 2'b11, 16'h0, 0, 10, term, np, er, mu, lv);
    n_checks++; if (term !== 0) begin n_fail++; $display("FAIL miss_term: got %0d want 0", term); end
    n_checks++; if (req_clks != r0) begin n_fail++; $display("FAIL miss_req: got %0d req clks want 0", req_clks - r0); end
    n_checks++; if (dout !== d0) begin n_fail++; $display("FAIL miss_dout: got %h want %h", dout, d0); end
    end_cycle(rel);
  endtask

  task automatic test_back_to_back();
    int term, np; bit er, mu, rel; logic [2:0] lv;
    ack_delay = 0;
    for (int i = 3; i < 5; i++) begin
      run_cycle(24'hFF8000 + 24'(i * 2), 3'b101, 1'b1, 2'b11, 16'h0, 0, 20, term, np, er, mu, lv);
      n_checks++; if (term !== 1 || dout !== ref_mem[i]) begin
        n_fail++; $display("FAIL b2b_read%0d: got term %0d dout %h want term 1 dout %h", i, term, dout, ref_mem[i]);
      end
      end_cycle(rel);
      n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL b2b_release%0d: got %b want 1", i, rel); end
    end
  endtask

  task automatic test_random();
    int term, np, idx, kind, exp_term, r0; bit er, mu, rel; logic [2:0] lv;
    logic [23:0] a; logic [2:0] f; logic rw; logic [1:0] be; logic [15:0] wd, d0;
    for (int it = 0; it < 24; it++) begin
      idx = int'($urandom_range(15, 0));
      kind = int'($urandom_range(9, 0));
      case ($urandom_range(2, 0))
        0: be = 2'b01;
        1: be = 2'b10;
        default: be = 2'b11;
      endcase
      rw = 1'($urandom_range(1, 0));
      wd = 16'($urandom);
      ack_delay = int'($urandom_range(3, 0));
      a = (kind == 0) ? (24'h001000 + 24'(idx * 2)) : (24'hFF8000 + 24'(idx * 2));
      if (kind == 1) f = $urandom_range(1, 0) ? 3'b001 : 3'b010;
      else f = $urandom_range(1, 0) ? 3'b101 : 3'b110;
      exp_term = (kind == 0) ? 0 : ((kind == 1) ? 2 : 1);
      d0 = dout; r0 = req_clks;
      run_cycle(a, f, rw, be, wd, rw ? 0 : 1, (kind == 0) ? 10 : 30, term, np, er, mu, lv);
      n_checks++; if (term !== exp_term) begin n_fail++; $display("FAIL rnd%0d_term: got %0d want %0d", it, term, exp_term); end
      n_checks++; if (mu !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_multi: got %b want 0", it, mu); end
      if (exp_term == 1) begin
        n_checks++; if (dev_addr !== a[23:1] || dev_be !== be || dev_we !== !rw) begin
          n_fail++; $display("FAIL rnd%0d_devport: got addr %h be %b we %b want %h %b %b", it, dev_addr, dev_be, dev_we, a[23:1], be, !rw);
        end
        if (rw) begin
          n_checks++; if (dout !== ref_mem[idx]) begin n_fail++; $display("FAIL rnd%0d_dout: got %h want %h", it, dout, ref_mem[idx]); end
        end else begin
          n_checks++; if (dev_wdata !== wd) begin n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", it, dev_wdata, wd); end
          if (be[1]) ref_mem[idx][15:8] = wd[15:8];
          if (be[0]) ref_mem[idx][7:0] = wd[7:0];
        end
      end else begin
        n_checks++; if (req_clks != r0 || dout !== d0) begin
          n_fail++; $display("FAIL rnd%0d_quiet: got %0d req clks dout %h want 0 and %h", it, req_clks - r0, dout, d0);
        end
      end
      end_cycle(rel);
      n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_release: got %b want 1", it, rel); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    ack_on = 1'b0;
    seen = 1'b0;
    addr = 24'hFF8000; fc = 3'b101; rw_n = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = dev_req;
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: got no dev_req want dev_req"); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (dev_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_drop: got %b want 0", dev_req); end
    n_checks++; if (dout !== 16'h0 || dev_addr !== 23'h0 || dev_be !== 2'b00 || dev_we !== 1'b0 || dev_wdata !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_regs: got dout %h addr %h be %b we %b wdata %h want zeros", dout, dev_addr, dev_be, dev_we, dev_wdata);
    end
    n_checks++; if (dtack_n !== 1'b1 || vpa_n !== 1'b1 || berr !== 1'b0 || iack_level !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_term: got dtack %b vpa %b berr %b lvl %0d want 1 1 0 0", dtack_n, vpa_n, berr, iack_level);
    end
    @(negedge clk);
    reset = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    ack_on = 1'b1;
    $display("reset during access done");
  endtask

  initial begin
    reset = 1'b1; as_n = 1'b1; rw_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    fc = 3'b000; addr = 24'h0; din = 16'h0; ivec_valid = 1'b0; ivec = 8'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_read();
    test_byte_write();
    test_user_berr();
    test_timeout();
    test_iack();
    test_miss();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
